regfile_fwd: RTL and testbench
==============================

Name: regfile_fwd

Overview:
- Parametrised general-purpose register file for the OpenMIPS core.
- Generalises the current 2-read/1-write regfile in three ways: configurable read-port count, a built-in operand bypass network from NUM_FWD younger pipeline stages (EX, MEM, …), and load-use hazard detection.
- Sits between ID (read side) and the WB/EX/MEM stage outputs (write and bypass side).
- Raises a stall request to the pipeline controller when an operand is still unavailable.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.
- NUM_RD, 2, number of read ports.
- NUM_FWD, 2, number of bypass sources; index 0 = youngest (EX), higher index = older.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- we  in  1  WB write enable.
- waddr  in  ADDR_W  WB write address.
- wdata  in  DATA_W  WB write data.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W].
- fwd_we  in  NUM_FWD  bypass source s will write a register.
- fwd_addr  in  NUM_FWD*ADDR_W  bypass destination addresses.
- fwd_data  in  NUM_FWD*DATA_W  bypass data, valid only if fwd_ld[s]=0.
- fwd_ld  in  NUM_FWD  source s is a load; data not yet available.
- stallreq  out  1  operand hazard; ID must hold.
- hazard_cnt  out  16  saturating count of stall cycles since reset.

Behaviour:
Storage and write:
- 2**ADDR_W registers; register 0 reads as 0 and is never written.
- Write: on posedge, if !rst && we && waddr!=0, mem[waddr] <= wdata.
- Reset (synchronous, rst=1 at posedge) clears all registers and hazard_cnt to 0.
- While rst=1, rdata=0 and stallreq=0 combinationally.
- Reset asserted mid-stream discards any write presented in that cycle.

Read path (combinational; no latency in rdata), per port p, first match wins:
1. rst=1, or re[p]=0, or raddr[p]=0 -> 0.
2. Lowest-index s with fwd_we[s]=1 and fwd_addr[s]=raddr[p] -> fwd_data[s]. If fwd_ld[s]=1, the port is hazardous and rdata is don't-care (drive fwd_data[s]).
3. we=1 and waddr=raddr[p] -> wdata (write-through).
4. Otherwise -> mem[raddr[p]].

Forwarding rules:
- A younger source shadows older sources and WB, even when the younger one is a load. The hazard is flagged rather than falling through to an older value.
- fwd_addr=0 never matches; register 0 is never forwarded.

stallreq and hazard_cnt:
- stallreq = OR over ports of hazard (registered view not required; combinational).
- hazard_cnt: on posedge, if !rst && stallreq, increment; saturates at 16'hFFFF and does not wrap.

Simultaneous events:
- WB write and read of the same address in the same cycle -> new data returned (rule 3).
- Two sources matching the same address -> youngest wins.
- we=1 with waddr=0 -> no effect.

Widths: all comparisons are full ADDR_W; no truncation or extension of data.

Test Plan:
1. Reset then read: assert rst 2 cycles, deassert; raddr0=5, re=2'b01 -> rdata0=0, stallreq=0, hazard_cnt=0.
2. Write/readback and write-through: we=1, waddr=3, wdata=32'hDEADBEEF with raddr1=3, re[1]=1 in the same cycle -> rdata1=32'hDEADBEEF immediately. Next cycle with we=0 -> still 32'hDEADBEEF.
3. Priority: mem[7]=1, WB writes 7<-2, fwd[1] (MEM) 7<-3, fwd[0] (EX) 7<-4 all at once, read 7 -> 4. Drop fwd_we[0] -> 3. Drop fwd_we[1] -> 2.
4. Load-use: fwd_we[0]=1, fwd_addr[0]=9, fwd_ld[0]=1, read port0 addr 9 -> stallreq=1. Hold 3 cycles -> hazard_cnt=3. Clear fwd_ld -> stallreq=0, rdata0=fwd_data[0].
5. Register 0: we=1, waddr=0, wdata=32'hFFFFFFFF; fwd_addr[0]=0 with fwd_ld=1; read 0 -> rdata=0, stallreq=0, stored value unchanged.
6. Reset mid-operation: write 32'h12345678 to r4 in the same cycle rst=1 -> after reset, read r4 = 0. Also force hazard_cnt to 16'hFFFF with a sustained stall, stall one more cycle -> remains 16'hFFFF.

Source files
------------

// File: rtl/regfile_fwd.sv
// General-purpose register file with combinational read ports, an operand bypass
// network from younger pipeline stages, and load-use hazard detection.
module regfile_fwd #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [NUM_RD-1:0]         re,
    input  logic [NUM_RD*ADDR_W-1:0]  raddr,
    output logic [NUM_RD*DATA_W-1:0]  rdata,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_ld,
    output logic                      stallreq,
    output logic [15:0]               hazard_cnt
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            hazard_cnt <= '0;
        end else begin
            if (we && waddr != '0) begin
                mem[waddr] <= wdata;
            end
            if (stallreq && hazard_cnt != 16'hFFFF) begin
                hazard_cnt <= hazard_cnt + 16'd1;
            end
        end
    end

    // Sources are scanned oldest to youngest so the youngest match overrides; the
    // zero-register/disable/reset check comes last so it also masks fwd_addr=0.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d;
        logic              h;
        rdata    = '0;
        stallreq = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = raddr[p*ADDR_W +: ADDR_W];
            d  = mem[ra];
            h  = 1'b0;
            if (we && waddr == ra) begin
                d = wdata;
            end
            for (int s = NUM_FWD - 1; s >= 0; s--) begin
                if (fwd_we[s] && fwd_addr[s*ADDR_W +: ADDR_W] == ra) begin
                    d = fwd_data[s*DATA_W +: DATA_W];
                    h = fwd_ld[s];
                end
            end
            if (rst || !re[p] || ra == '0) begin
                d = '0;
                h = 1'b0;
            end
            rdata[p*DATA_W +: DATA_W] = d;
            stallreq = stallreq | h;
        end
    end

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: directed vector table, randomized traffic
// against a behavioural model, and hazard counter saturation.
module tb_regfile_fwd;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_ld;
    logic        stallreq;
    logic [15:0] hazard_cnt;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [32];
    int          m_cnt = 0;

    regfile_fwd dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ld(fwd_ld),
        .stallreq(stallreq), .hazard_cnt(hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic [1:0]  fwe;
        logic [4:0]  fa0, fa1;
        logic [31:0] fd0, fd1;
        logic [1:0]  fld;
        logic [31:0] e0, e1;
        logic        es;
        logic [15:0] ec;
        logic [3:0]  chk;
    } vec_t;

    vec_t vecs[$];

    // Reference read: first matching rule wins, youngest bypass source searched first.
    function automatic logic [32:0] m_port(input int p);
        logic [4:0] a;
        a = raddr[p*5 +: 5];
        if (rst || !re[p] || a == 5'd0) return 33'd0;
        for (int s = 0; s < 2; s++) begin
            if (fwd_we[s] && fwd_addr[s*5 +: 5] == a) return {fwd_ld[s], fwd_data[s*32 +: 32]};
        end
        if (we && waddr == a) return {1'b0, wdata};
        return {1'b0, m_mem[a]};
    endfunction

    always @(posedge clk) begin
        logic stall;
        stall = m_port(0)[32] | m_port(1)[32];
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            m_cnt = 0;
        end else begin
            if (we && waddr != 5'd0) m_mem[waddr] = wdata;
            if (stall && m_cnt < 65535) m_cnt++;
        end
    end

    task automatic add(input logic r, w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] rr, input logic [4:0] a0, a1,
                       input logic [1:0] fw, input logic [4:0] f0, f1,
                       input logic [31:0] d0, d1, input logic [1:0] fl,
                       input logic [31:0] x0, x1, input logic xs, input logic [15:0] xc,
                       input logic [3:0] ck);
        vec_t v;
        v.rst = r; v.we = w; v.waddr = wa; v.wdata = wd; v.re = rr; v.ra0 = a0; v.ra1 = a1;
        v.fwe = fw; v.fa0 = f0; v.fa1 = f1; v.fd0 = d0; v.fd1 = d1; v.fld = fl;
        v.e0 = x0; v.e1 = x1; v.es = xs; v.ec = xc; v.chk = ck;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata; re = v.re;
        raddr = {v.ra1, v.ra0}; fwd_we = v.fwe; fwd_addr = {v.fa1, v.fa0};
        fwd_data = {v.fd1, v.fd0}; fwd_ld = v.fld;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic randomCycle();
        vec_t v;
        v.rst = ($urandom_range(0, 39) == 0); v.we = 1'($urandom);
        v.waddr = 5'($urandom_range(0, 7)); v.wdata = $urandom; v.re = 2'($urandom);
        v.ra0 = 5'($urandom_range(0, 7)); v.ra1 = 5'($urandom_range(0, 7));
        v.fwe = 2'($urandom); v.fa0 = 5'($urandom_range(0, 7)); v.fa1 = 5'($urandom_range(0, 7));
        v.fd0 = $urandom; v.fd1 = $urandom;
        v.fld = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        applyStimulus(v);
    endtask

    initial begin
        logic [32:0] p0, p1;
        rst = 1'b1; we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0;
        fwd_we = 0; fwd_addr = 0; fwd_data = 0; fwd_ld = 0;

        add(1,0,0,0,           2'b11,5,5,  2'b00,0,0,0,0,2'b00,            0,0,0,0, 4'b0111);
        add(1,1,4,32'h12345678,2'b01,4,0,  2'b01,4,0,32'h11,0,2'b01,       0,0,0,0, 4'b1111);
        add(0,0,0,0,           2'b11,5,4,  2'b00,0,0,0,0,2'b00,            0,0,0,0, 4'b1111);
        add(0,1,3,32'hDEADBEEF,2'b10,3,3,  2'b00,0,0,0,0,2'b00,            0,32'hDEADBEEF,0,0, 4'b1111);
        add(0,0,0,0,           2'b11,3,3,  2'b00,0,0,0,0,2'b00,            32'hDEADBEEF,32'hDEADBEEF,0,0, 4'b1111);
        add(0,1,7,1,           2'b00,7,7,  2'b00,0,0,0,0,2'b00,            0,0,0,0, 4'b1111);
        add(0,1,7,2,           2'b01,7,0,  2'b11,7,7,4,3,2'b00,            4,0,0,0, 4'b1111);
        add(0,1,7,2,           2'b01,7,0,  2'b10,7,7,4,3,2'b00,            3,0,0,0, 4'b1111);
        add(0,1,7,2,           2'b11,7,7,  2'b00,7,7,4,3,2'b00,            2,2,0,0, 4'b1111);
        add(0,0,7,2,           2'b01,7,0,  2'b00,0,0,0,0,2'b00,            2,0,0,0, 4'b1111);
        for (int i = 0; i < 3; i++)
            add(0,0,0,0,       2'b01,9,0,  2'b01,9,0,32'hAAAA,0,2'b01,     32'hAAAA,0,1,16'(i), 4'b1111);
        add(0,0,0,0,           2'b01,9,0,  2'b01,9,0,32'hAAAA,0,2'b00,     32'hAAAA,0,0,3, 4'b1111);
        add(0,0,0,0,           2'b01,9,0,  2'b11,9,9,32'hAAAA,32'hBBBB,2'b01, 32'hAAAA,0,1,3, 4'b1111);
        add(0,0,0,0,           2'b01,9,0,  2'b10,9,9,32'hAAAA,32'hBBBB,2'b01, 32'hBBBB,0,0,4, 4'b1111);
        add(0,1,0,32'hFFFFFFFF,2'b11,0,0,  2'b01,0,0,5,0,2'b01,            0,0,0,4, 4'b1111);
        add(0,0,0,0,           2'b11,0,3,  2'b00,0,0,0,0,2'b00,            0,32'hDEADBEEF,0,4, 4'b1111);
        add(0,0,0,0,           2'b10,0,12, 2'b10,0,12,0,32'hCC,2'b10,      0,32'hCC,1,4, 4'b1111);
        add(0,0,0,0,           2'b00,0,12, 2'b10,0,12,0,32'hCC,2'b10,      0,0,0,5, 4'b1111);
        add(0,1,4,32'h12345678,2'b01,4,0,  2'b00,0,0,0,0,2'b00,            32'h12345678,0,0,5, 4'b1111);
        add(1,1,4,32'h87654321,2'b01,4,0,  2'b00,0,0,0,0,2'b00,            0,0,0,5, 4'b1111);
        add(0,0,0,0,           2'b11,4,3,  2'b00,0,0,0,0,2'b00,            0,0,0,0, 4'b1111);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            if (vecs[i].chk[0]) checkOutput($sformatf("vec%0d rdata0", i), rdata[31:0], vecs[i].e0);
            if (vecs[i].chk[1]) checkOutput($sformatf("vec%0d rdata1", i), rdata[63:32], vecs[i].e1);
            if (vecs[i].chk[2]) checkOutput($sformatf("vec%0d stallreq", i), 32'(stallreq), 32'(vecs[i].es));
            if (vecs[i].chk[3]) checkOutput($sformatf("vec%0d hazard_cnt", i), 32'(hazard_cnt), 32'(vecs[i].ec));
        end

        for (int i = 0; i < 300; i++) begin
            randomCycle();
            p0 = m_port(0);
            p1 = m_port(1);
            checkOutput($sformatf("rnd%0d rdata0", i), rdata[31:0], p0[31:0]);
            checkOutput($sformatf("rnd%0d rdata1", i), rdata[63:32], p1[31:0]);
            checkOutput($sformatf("rnd%0d stallreq", i), 32'(stallreq), 32'(p0[32] | p1[32]));
            checkOutput($sformatf("rnd%0d hazard_cnt", i), 32'(hazard_cnt), 32'(m_cnt));
        end

        // Sustained load-use stall long enough to drive the counter into saturation.
        @(negedge clk);
        rst = 0; we = 0; re = 2'b01; raddr = {5'd0, 5'd9};
        fwd_we = 2'b01; fwd_addr = {5'd0, 5'd9}; fwd_ld = 2'b01; fwd_data = 64'h1;
        for (int i = 0; i < 70000 && m_cnt < 65535; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("sat hazard_cnt", 32'(hazard_cnt), 32'hFFFF);
        checkOutput("sat stallreq", 32'(stallreq), 32'd1);
        @(negedge clk);
        checkOutput("sat hold hazard_cnt", 32'(hazard_cnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
